// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALUOp codes, funct values and
// the multiply/divide unit state encoding.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle. The pipeline side (master) drives the
// ID/EX fields; the execute stage (slave) returns the EX/MEM fields.
interface ex_stage_if #(parameter int DATA_W = 32);

  logic [1:0]        wb_i;
  logic [2:0]        m_i;
  logic              regdst_i;
  logic              alusrc_i;
  logic [1:0]        aluop_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] rd1_i;
  logic [DATA_W-1:0] rd2_i;
  logic [DATA_W-1:0] imm_i;
  logic [4:0]        shamt_i;
  logic [4:0]        rt_i;
  logic [4:0]        rd_i;
  logic              beq_bne_i;
  logic              jump_i;
  logic [25:0]       j_i;

  logic [DATA_W-1:0] alu_result_o;
  logic              zero_o;
  logic [DATA_W-1:0] rd2_o;
  logic [4:0]        write_reg_o;
  logic [DATA_W-1:0] branch_target_o;
  logic [DATA_W-1:0] jump_target_o;
  logic [1:0]        wb_o;
  logic [2:0]        m_o;
  logic              beq_bne_o;
  logic              jump_o;
  logic              stall_o;
  logic              md_busy_o;

  modport master (
    output wb_i, m_i, regdst_i, alusrc_i, aluop_i, pc_i, rd1_i, rd2_i, imm_i,
           shamt_i, rt_i, rd_i, beq_bne_i, jump_i, j_i,
    input  alu_result_o, zero_o, rd2_o, write_reg_o, branch_target_o,
           jump_target_o, wb_o, m_o, beq_bne_o, jump_o, stall_o, md_busy_o
  );

  modport slave (
    input  wb_i, m_i, regdst_i, alusrc_i, aluop_i, pc_i, rd1_i, rd2_i, imm_i,
           shamt_i, rt_i, rd_i, beq_bne_i, jump_i, j_i,
    output alu_result_o, zero_o, rd2_o, write_reg_o, branch_target_o,
           jump_target_o, wb_o, m_o, beq_bne_o, jump_o, stall_o, md_busy_o
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / restoring divide, one bit per clock.
// A shared 2*DATA_W accumulator holds {partial, multiplier} for MUL and
// {remainder, quotient} for DIV; HI/LO are updated only on completion.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MD_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_mul,
  input  logic              start_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  localparam int CNT_W = $clog2(MD_ITER + 1);

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [2*DATA_W-1:0] acc_q, acc_step;
  logic [DATA_W-1:0]   opnd_q, hi_q, lo_q;
  logic [DATA_W:0]     mul_sum, div_shift, div_trial;
  logic                last_iter;

  assign last_iter = (count_q == CNT_W'(1));

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: launch from IDLE, return to IDLE after the last iteration.
  // NOTE: state_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_mul)      state_d = MUL;
                else if (start_div) state_d = DIV;
      MUL, DIV: if (last_iter)      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // One shift-add or restoring-subtract step on the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
              + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    acc_step  = acc_q;
    if (state_q == MUL) begin
      acc_step = {mul_sum, acc_q[DATA_W-1:1]};
    end else if (state_q == DIV) begin
      // Unsigned compare keeps divide-by-zero well defined: every step
      // succeeds, giving an all-ones quotient and the dividend as remainder.
      if (div_shift >= {1'b0, opnd_q})
        acc_step = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      else
        acc_step = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end
  end

  // Operand capture, iteration counter and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (state_q == IDLE) begin
      if (start_mul || start_div) begin
        count_q <= CNT_W'(MD_ITER);
        opnd_q  <= start_mul ? a : b;
        acc_q   <= {{DATA_W{1'b0}}, (start_mul ? b : a)};
      end
    end else begin
      count_q <= count_q - CNT_W'(1);
      acc_q   <= acc_step;
      if (last_iter) begin
        hi_q <= acc_step[2*DATA_W-1:DATA_W];
        lo_q <= acc_step[DATA_W-1:0];
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch/jump targets, destination select and the
// multiply/divide interlock. Outputs are combinational; EX/MEM registers them.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MD_ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  ex
);

  logic [5:0]        funct;
  logic              is_rtype, is_multu, is_divu, is_md_op;
  logic [DATA_W-1:0] op_b, result, hi, lo;
  logic              md_busy, stall;

  assign funct    = ex.imm_i[5:0];
  assign is_rtype = (ex.aluop_i == ALUOP_RTYPE);
  assign is_multu = is_rtype && (funct == FN_MULTU);
  assign is_divu  = is_rtype && (funct == FN_DIVU);
  assign is_md_op = is_multu || is_divu ||
                    (is_rtype && (funct == FN_MFHI || funct == FN_MFLO));
  assign op_b     = ex.alusrc_i ? ex.imm_i : ex.rd2_i;

  // Only instructions that touch HI/LO wait for the unit.
  assign stall = md_busy && is_md_op;

  muldiv_unit #(.DATA_W(DATA_W), .MD_ITER(MD_ITER)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start_mul (is_multu && !stall),
    .start_div (is_divu && !stall),
    .a         (ex.rd1_i),
    .b         (ex.rd2_i),
    .hi        (hi),
    .lo        (lo),
    .busy      (md_busy)
  );

  // ALU operation select; all arithmetic wraps.
  always_comb begin
    result = '0;
    case (ex.aluop_i)
      ALUOP_ADD: result = ex.rd1_i + op_b;
      ALUOP_SUB: result = ex.rd1_i - op_b;
      ALUOP_OR:  result = ex.rd1_i | op_b;
      default: begin
        case (funct)
          FN_ADD:  result = ex.rd1_i + op_b;
          FN_SUB:  result = ex.rd1_i - op_b;
          FN_AND:  result = ex.rd1_i & op_b;
          FN_OR:   result = ex.rd1_i | op_b;
          FN_SLT:  result = ($signed(ex.rd1_i) < $signed(op_b))
                            ? DATA_W'(1) : '0;
          FN_SLL:  result = ex.rd2_i << ex.shamt_i;
          FN_SRL:  result = ex.rd2_i >> ex.shamt_i;
          FN_MFHI: result = hi;
          FN_MFLO: result = lo;
          default: result = '0;
        endcase
      end
    endcase
  end

  assign ex.alu_result_o    = result;
  assign ex.zero_o          = (result == '0);
  assign ex.rd2_o           = ex.rd2_i;
  assign ex.write_reg_o     = ex.regdst_i ? ex.rd_i : ex.rt_i;
  assign ex.branch_target_o = ex.pc_i + (ex.imm_i << 2);
  assign ex.jump_target_o   = {ex.pc_i[DATA_W-1:DATA_W-4], ex.j_i, 2'b00};
  // A stalled instruction becomes a bubble; MULTU/DIVU never write a GPR.
  assign ex.wb_o            = (stall || is_multu || is_divu) ? 2'b00 : ex.wb_i;
  assign ex.m_o             = stall ? 3'b000 : ex.m_i;
  assign ex.beq_bne_o       = ex.beq_bne_i;
  assign ex.jump_o          = ex.jump_i;
  assign ex.stall_o         = stall;
  assign ex.md_busy_o       = md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver predicts each cycle's outputs
// from an arithmetic model of the stage and queues them; a negedge monitor
// pops and compares against what the DUT presents.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if #(.DATA_W(32)) bus ();

  ex_stage #(.DATA_W(32), .MD_ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        regdst, alusrc;
    logic [1:0]  aluop;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  shamt, rt, rd;
    logic        beq, jump;
    logic [25:0] j;
  } instr_t;

  typedef struct {
    string       tag;
    logic [31:0] result, rd2, bt, jt;
    logic        zero, beq, jump, stall, busy;
    logic [4:0]  wr;
    logic [1:0]  wb;
    logic [2:0]  m;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Model of HI/LO: values before and after the in-flight operation, and
  // the last cycle in which the unit reports busy.
  int          md_end = -1;
  logic [31:0] hi_old = '0, lo_old = '0, hi_new = '0, lo_new = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.tag, ".result"}, 64'(bus.alu_result_o),    64'(mon_e.result));
      check({mon_e.tag, ".zero"},   64'(bus.zero_o),          64'(mon_e.zero));
      check({mon_e.tag, ".rd2"},    64'(bus.rd2_o),           64'(mon_e.rd2));
      check({mon_e.tag, ".wreg"},   64'(bus.write_reg_o),     64'(mon_e.wr));
      check({mon_e.tag, ".btgt"},   64'(bus.branch_target_o), 64'(mon_e.bt));
      check({mon_e.tag, ".jtgt"},   64'(bus.jump_target_o),   64'(mon_e.jt));
      check({mon_e.tag, ".wb"},     64'(bus.wb_o),            64'(mon_e.wb));
      check({mon_e.tag, ".m"},      64'(bus.m_o),             64'(mon_e.m));
      check({mon_e.tag, ".beq"},    64'(bus.beq_bne_o),       64'(mon_e.beq));
      check({mon_e.tag, ".jump"},   64'(bus.jump_o),          64'(mon_e.jump));
      check({mon_e.tag, ".stall"},  64'(bus.stall_o),         64'(mon_e.stall));
      check({mon_e.tag, ".busy"},   64'(bus.md_busy_o),       64'(mon_e.busy));
    end
  end

  function automatic instr_t nop();
    instr_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic instr_t r_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    instr_t t;
    t.wb = 2'($urandom);   t.m = 3'($urandom);
    t.regdst = 1'($urandom); t.alusrc = 1'b0; t.aluop = ALUOP_RTYPE;
    t.pc = $urandom;       t.rd1 = a; t.rd2 = b;
    t.imm = {26'($urandom), f};
    t.shamt = 5'($urandom); t.rt = 5'($urandom); t.rd = 5'($urandom);
    t.beq = 1'($urandom);  t.jump = 1'($urandom); t.j = 26'($urandom);
    return t;
  endfunction

  // Reference model: expected outputs for instruction i in cycle cyc.
  task automatic predict(input instr_t i, input string tag, input bit is_rst, output exp_t e);
    int          c     = cyc;
    logic [5:0]  f     = i.imm[5:0];
    bit          rtype = (i.aluop == 2'b10);
    bit          busy  = (c <= md_end);
    logic [31:0] hi_v  = (c > md_end) ? hi_new : hi_old;
    logic [31:0] lo_v  = (c > md_end) ? lo_new : lo_old;
    logic [31:0] b     = i.alusrc ? i.imm : i.rd2;
    bit          is_mul = rtype && (f == FN_MULTU);
    bit          is_div = rtype && (f == FN_DIVU);
    bit          uses_hilo = is_mul || is_div || (rtype && (f == FN_MFHI || f == FN_MFLO));
    logic [31:0] res;
    logic [63:0] prod;

    res = 32'd0;
    if (i.aluop == 2'b00)      res = i.rd1 + b;
    else if (i.aluop == 2'b01) res = i.rd1 - b;
    else if (i.aluop == 2'b11) res = i.rd1 | b;
    else if (f == FN_ADD)      res = i.rd1 + b;
    else if (f == FN_SUB)      res = i.rd1 - b;
    else if (f == FN_AND)      res = i.rd1 & b;
    else if (f == FN_OR)       res = i.rd1 | b;
    else if (f == FN_SLT)      res = ($signed(i.rd1) < $signed(b)) ? 32'd1 : 32'd0;
    else if (f == FN_SLL)      res = i.rd2 << i.shamt;
    else if (f == FN_SRL)      res = i.rd2 >> i.shamt;
    else if (f == FN_MFHI)     res = hi_v;
    else if (f == FN_MFLO)     res = lo_v;

    e.tag    = tag;
    e.busy   = busy;
    e.stall  = busy && uses_hilo;
    e.result = res;
    e.zero   = (res == 32'd0);
    e.rd2    = i.rd2;
    e.wr     = i.regdst ? i.rd : i.rt;
    e.bt     = i.pc + i.imm * 4;
    e.jt     = {i.pc[31:28], i.j, 2'b00};
    e.wb     = (e.stall || is_mul || is_div) ? 2'b00 : i.wb;
    e.m      = e.stall ? 3'b000 : i.m;
    e.beq    = i.beq;
    e.jump   = i.jump;

    if (is_rst) begin
      hi_old = '0; lo_old = '0; hi_new = '0; lo_new = '0;
      md_end = c;
    end else if ((is_mul || is_div) && !e.stall) begin
      hi_old = hi_new;
      lo_old = lo_new;
      if (is_mul) begin
        prod   = {32'd0, i.rd1} * {32'd0, i.rd2};
        hi_new = prod[63:32];
        lo_new = prod[31:0];
      end else if (i.rd2 == 32'd0) begin
        hi_new = i.rd1;
        lo_new = 32'hFFFF_FFFF;
      end else begin
        hi_new = i.rd1 % i.rd2;
        lo_new = i.rd1 / i.rd2;
      end
      md_end = c + 32;
    end
  endtask

  task automatic drive(input instr_t i);
    bus.wb_i = i.wb;         bus.m_i = i.m;
    bus.regdst_i = i.regdst; bus.alusrc_i = i.alusrc; bus.aluop_i = i.aluop;
    bus.pc_i = i.pc;         bus.rd1_i = i.rd1;       bus.rd2_i = i.rd2;
    bus.imm_i = i.imm;       bus.shamt_i = i.shamt;
    bus.rt_i = i.rt;         bus.rd_i = i.rd;
    bus.beq_bne_i = i.beq;   bus.jump_i = i.jump;     bus.j_i = i.j;
  endtask

  // Present an instruction, holding it in EX while the model predicts a stall.
  task automatic issue(input instr_t i, input string tag, input bit is_rst = 1'b0);
    exp_t e;
    int   tries = 0;
    do begin
      drive(i);
      rst = is_rst;
      predict(i, tag, is_rst, e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      tries++;
    end while (e.stall && tries < 40);
    rst = 1'b0;
  endtask

  initial begin
    instr_t t;
    int     kind;
    logic [5:0] f;
    logic [5:0] alu_fns [8];
    alu_fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, 6'b111111};

    drive(nop());
    @(posedge clk);
    #1;
    issue(nop(), "reset", 1'b1);

    t = r_op(FN_ADD, 32'd7, 32'hFFFF_FFFF); t.regdst = 1'b1; t.rd = 5'd9;
    issue(t, "add_wrap");
    issue(r_op(FN_SUB, 32'd5, 32'd5), "sub_zero");
    t = nop(); t.aluop = ALUOP_SUB; t.beq = 1'b1; t.pc = 32'h100; t.imm = 32'hFFFF_FFFE;
    issue(t, "branch");
    t = nop(); t.jump = 1'b1; t.j = 26'h40; t.pc = 32'h1000_0004;
    issue(t, "jump");

    issue(r_op(FN_MULTU, 32'hFFFF_FFFF, 32'd2), "multu");
    issue(r_op(FN_MFHI, 32'd0, 32'd0), "mfhi_wait");
    issue(r_op(FN_MFLO, 32'd0, 32'd0), "mflo");

    issue(r_op(FN_DIVU, 32'd100, 32'd7), "divu");
    issue(r_op(FN_MFLO, 32'd0, 32'd0), "divu_lo");
    issue(r_op(FN_MFHI, 32'd0, 32'd0), "divu_hi");
    issue(r_op(FN_DIVU, 32'd5, 32'd0), "divu_zero");
    issue(r_op(FN_MFLO, 32'd0, 32'd0), "dz_lo");
    issue(r_op(FN_MFHI, 32'd0, 32'd0), "dz_hi");

    issue(r_op(FN_MULTU, 32'd3, 32'd4), "multu_a");
    issue(r_op(FN_MULTU, 32'd5, 32'd6), "multu_b2b");
    issue(r_op(FN_ADD, 32'd1, 32'd2), "indep_add");
    issue(r_op(FN_MFLO, 32'd0, 32'd0), "b2b_lo");

    issue(r_op(FN_DIVU, 32'd1000, 32'd3), "divu_rst");
    for (int k = 0; k < 9; k++) issue(r_op(FN_OR, $urandom, $urandom), "busy_or");
    issue(nop(), "rst_mid", 1'b1);
    issue(r_op(FN_MFHI, 32'd0, 32'd0), "post_rst_hi");
    issue(r_op(FN_MFLO, 32'd0, 32'd0), "post_rst_lo");

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        f = alu_fns[$urandom_range(0, 7)];
        t = r_op(f, $urandom, $urandom);
        if (kind == 0) t.rd2 = t.rd1;
        issue(t, "rnd_r");
      end else if (kind == 5) begin
        t = r_op(FN_ADD, $urandom, $urandom);
        t.aluop = 2'($urandom_range(0, 3));
        if (t.aluop == ALUOP_RTYPE) t.aluop = ALUOP_OR;
        t.alusrc = 1'($urandom);
        issue(t, "rnd_i");
      end else if (kind == 6) begin
        issue(r_op(FN_MULTU, $urandom, $urandom), "rnd_mul");
      end else if (kind == 7) begin
        t = r_op(FN_DIVU, $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(1, 5000)));
        issue(t, "rnd_div");
      end else begin
        issue(r_op(kind == 8 ? FN_MFHI : FN_MFLO, $urandom, $urandom), "rnd_mf");
      end
    end

    drive(nop());
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It sits between the ID/EX and EX/MEM pipeline registers.
- Performs ALU operations, branch-target and jump-target generation, and destination-register selection.
- Holds an iterative 32-cycle MULTU/DIVU unit with HI/LO registers.
- Stalls upstream when a dependent instruction reaches EX while that unit is busy.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
MD_ITER, 32, multiply/divide iterations; must equal DATA_W.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wb_i  in  2  WB control from ID/EX
m_i  in  3  MEM control from ID/EX
regdst_i  in  1  1 = rd is destination, 0 = rt
alusrc_i  in  1  1 = operand B is immediate
aluop_i  in  2  00 add, 01 sub, 10 R-type (funct), 11 or
pc_i  in  32  PC+4 of instruction
rd1_i / rd2_i  in  32  register operands
imm_i  in  32  extended immediate; imm_i[5:0] is funct
shamt_i  in  5  shift amount
rt_i / rd_i  in  5  register numbers
beq_bne_i / jump_i  in  1  branch/jump flags
j_i  in  26  jump index
alu_result_o  out  32  ALU result
zero_o  out  1  alu_result_o == 0
rd2_o  out  32  store data (rd2_i pass-through)
write_reg_o  out  5  destination register
branch_target_o  out  32  pc_i + (imm_i << 2)
jump_target_o  out  32  {pc_i[31:28], j_i, 2'b00}
wb_o / m_o  out  2/3  control to EX/MEM
beq_bne_o / jump_o  out  1  pass-through
stall_o  out  1  1 = PC, IF/ID and ID/EX hold their contents
md_busy_o  out  1  multiply/divide in progress

Behaviour:
- Datapath outputs are combinational from the inputs and the HI/LO registers; EX/MEM does the registering.
- Operand B is imm_i when alusrc_i = 1, else rd2_i.
- When aluop_i = 10, the operation is selected by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or.
  - 101010 slt: signed compare, result 1 or 0.
  - 000000 sll: rd2_i << shamt_i. 000010 srl: rd2_i >> shamt_i, logical.
  - 011001 MULTU, 011011 DIVU, 010000 MFHI, 010010 MFLO.
  - Any other funct gives result 0.
- All adds and subtracts wrap modulo 2^32; there is no overflow trap.
- MULTU/DIVU produce alu_result_o = 0 and force wb_o = 00.
- Multiply/divide unit states: IDLE, MUL, DIV.
  - IDLE -> MUL/DIV on the clock edge where MULTU/DIVU is in EX and stall_o = 0. Operands rd1_i and rd2_i are latched, count = MD_ITER, md_busy_o = 1.
  - MUL is a shift-add multiply; DIV is a restoring divide. One iteration per edge.
  - On the edge where count reaches 0, HI/LO are written and the state returns to IDLE with md_busy_o = 0.
  - Latency: MULTU/DIVU in EX at cycle N gives busy in cycles N+1 to N+32; HI/LO are readable from cycle N+33.
  - MULTU: {HI, LO} = 64-bit unsigned product.
  - DIVU: LO = quotient, HI = remainder.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend; no exception.
- stall_o = md_busy_o AND (EX instruction is MULTU, DIVU, MFHI or MFLO).
  - While stall_o = 1, wb_o and m_o are forced to 0, inserting a bubble into EX/MEM.
  - The instruction is held in EX and re-evaluated each cycle.
  - The held MULTU/DIVU starts on the edge after the unit returns to IDLE.
- Independent instructions proceed normally while the unit is busy.
- Reset, including mid-operation: state IDLE, count 0, HI = LO = 0, md_busy_o = 0, stall_o = 0. All combinational outputs follow the reset-zeroed ID/EX inputs.

Decomposition:
- Shared package ex_pkg: ALUOp codes, funct constants, and the muldiv state enum {IDLE, MUL, DIV}.
- Sub-module muldiv_unit: owns the state machine, counter, operand, HI and LO registers.
  - Inputs: start_mul, start_div, a, b.
  - Outputs: hi, lo, busy.
- ALU and mux logic stay in ex_stage.

Test Plan:
- R-type add, rd1 = 7, rd2 = 0xFFFFFFFF, regdst = 1, rd = 9 -> result 6, zero_o = 0, write_reg_o = 9; sub 5-5 -> zero_o = 1.
- aluop = 01, beq_bne = 1, pc = 0x100, imm = 0xFFFFFFFE -> branch_target_o = 0x0F8; j_i = 0x40, pc = 0x10000004 -> jump_target_o = 0x10000100.
- MULTU 0xFFFFFFFF × 2 at cycle N, then MFHI next -> stall_o = 1 for cycles N+1 to N+32 with wb_o = m_o = 0; at N+33 result = 1, and MFLO then returns 0xFFFFFFFE.
- DIVU 100 ÷ 7 -> LO = 14, HI = 2; DIVU 5 ÷ 0 -> LO = 0xFFFFFFFF, HI = 5.
- Back-to-back MULTU -> second stalls 32 cycles and starts on the edge after idle; an independent add during busy -> no stall.
- rst asserted at iteration 10 of DIVU -> next cycle md_busy_o = 0, HI = LO = 0, stall_o = 0; MFHI returns 0.
